regfile_wb: RTL and testbench
=============================

REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 Parameter DATA_W, default 32: register data width.
REQ-002 Parameter ADDR_W, default 5: register address width; depth = 2**ADDR_W (32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 we  input  1  write-back enable.
REQ-006 wa  input  ADDR_W  write-back destination register, produced by the destination-select mux.
REQ-007 wd  input  DATA_W  write-back data.
REQ-008 ra1  input  ADDR_W  read port 1 address (rs).
REQ-009 ra2  input  ADDR_W  read port 2 address (rt).
REQ-010 rd1  output  DATA_W  read port 1 data.
REQ-011 rd2  output  DATA_W  read port 2 data.
REQ-012 ld_issue  input  1  load issued this cycle; its destination becomes pending.
REQ-013 ld_dst  input  ADDR_W  destination register of the issued load.
REQ-014 ld_done  input  1  qualifies we: this write-back retires a pending load.
REQ-015 stall  output  1  ra1 or ra2 targets a pending-load register.

Function
REQ-016 Storage SHALL be 32 x DATA_W flip-flops, written on the rising edge of clk when we=1 and wa!=0.
REQ-017 Register 0 SHALL always read 0; writes to wa=0 SHALL be discarded.
REQ-018 Reads SHALL be combinational: rd1 = reg[ra1], rd2 = reg[ra2].
REQ-019 Write-through bypass: when we=1, wa!=0 and wa==ra1 (or ra2), rd1 (or rd2) SHALL return wd in the same cycle.
REQ-020 Scoreboard: one pending bit per register; ld_issue=1 with ld_dst!=0 SHALL set bit ld_dst at the next edge.
REQ-021 we=1 and ld_done=1 SHALL clear pending bit wa at the next edge.
REQ-022 If ld_issue sets and ld_done clears the same index in one cycle, the bit SHALL end set (new load wins).
REQ-023 ld_issue with ld_dst=0 SHALL be ignored; pending bit 0 SHALL be constant 0.
REQ-024 stall SHALL be combinational: pending[ra1] | pending[ra2], with bypass.
REQ-025 stall bypass: a port SHALL NOT stall if its register is being retired this cycle (we & ld_done & wa==port address).
REQ-026 ld_done=1 with we=0 SHALL have no effect.
REQ-027 ld_done on a register that is not pending SHALL perform a normal write and leave the bit clear.
REQ-028 Write latency: data written at edge N SHALL be visible through the array from cycle N onward; bypass covers cycle N-1.

Reset
REQ-029 rst=1 SHALL immediately clear all 32 registers and all pending bits, regardless of clk.
REQ-030 While rst=1, rd1, rd2 and stall SHALL read 0 and we and ld_issue SHALL be ignored.
REQ-031 Reset de-assertion mid-stream SHALL resume normal operation at the first rising edge after release.

Structure
REQ-032 DATA_W, ADDR_W, the depth constant and the zero-register index SHALL live in the shared MIPS package.
REQ-033 The pending-load scoreboard SHALL be a separate sub-module, load_scoreboard (clk, rst, set/clear ports, two lookup ports).
REQ-034 The array and the bypass logic SHALL remain in regfile_wb.

Verification
REQ-035 Reset then read all 32 registers -> rd1=rd2=0, stall=0.
REQ-036 we=1, wa=5, wd=0xDEADBEEF, ra1=5 in the same cycle -> rd1=0xDEADBEEF (bypass); next cycle with we=0 -> rd1=0xDEADBEEF from the array.
REQ-037 we=1, wa=0, wd=0xFFFFFFFF; then ra1=0 -> rd1=0.
REQ-038 ld_issue, ld_dst=8; next cycle ra2=8 -> stall=1; then we=1, ld_done=1, wa=8, wd=0x1234 -> stall=0 and rd2=0x1234 that cycle.
REQ-039 ld_issue, ld_dst=9 in the same cycle as we=1, ld_done=1, wa=9 -> pending[9] stays 1 and ra1=9 stalls next cycle.
REQ-040 Write reg 3=0x55, set pending 3, pulse rst asynchronously between edges -> reg 3 reads 0 and stall=0 immediately.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared MIPS register-file constants: widths, depth and the hard-wired zero register.
package regfile_wb_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 2**ADDR_W;
    localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_wb_if.sv
// Write-back / read / load-tracking bundle between the pipeline (master) and the register file (slave).
interface regfile_wb_if #(
    parameter int DATA_W = regfile_wb_pkg::DATA_W,
    parameter int ADDR_W = regfile_wb_pkg::ADDR_W
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              ld_issue;
    logic [ADDR_W-1:0] ld_dst;
    logic              ld_done;
    logic              stall;

    modport master (
        output we, wa, wd, ra1, ra2, ld_issue, ld_dst, ld_done,
        input  rd1, rd2, stall
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, ld_issue, ld_dst, ld_done,
        output rd1, rd2, stall
    );
endinterface

// File: rtl/regfile_wb_load_scoreboard.sv
// One pending bit per register for loads in flight; a new issue outranks a same-cycle retire.
module load_scoreboard #(
    parameter int ADDR_W = regfile_wb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] la1,
    input  logic [ADDR_W-1:0] la2,
    output logic              pend1,
    output logic              pend2
);
    import regfile_wb_pkg::*;

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nx;

    always_comb begin
        pending_nx = pending;
        if (clr_en) pending_nx[clr_idx] = 1'b0;
        if (set_en) pending_nx[set_idx] = 1'b1;
        pending_nx[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_nx;
    end

    assign pend1 = pending[la1];
    assign pend2 = pending[la2];
endmodule

// File: rtl/regfile_wb.sv
// Two-read / one-write register file with write-through bypass and load-use stall detection.
module regfile_wb #(
    parameter int DATA_W = regfile_wb_pkg::DATA_W,
    parameter int ADDR_W = regfile_wb_pkg::ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  bus
);
    import regfile_wb_pkg::*;

    localparam int                NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZREG = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_en;
    logic              retire;
    logic              pend1;
    logic              pend2;

    assign wr_en  = bus.we && (bus.wa != ZREG);
    assign retire = wr_en && bus.ld_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    // Bypass presents this cycle's write-back a cycle before the array holds it.
    always_comb begin
        bus.rd1 = regs[bus.ra1];
        bus.rd2 = regs[bus.ra2];
        if (wr_en && bus.wa == bus.ra1) bus.rd1 = bus.wd;
        if (wr_en && bus.wa == bus.ra2) bus.rd2 = bus.wd;
        if (bus.ra1 == ZREG) bus.rd1 = '0;
        if (bus.ra2 == ZREG) bus.rd2 = '0;
        if (rst) begin
            bus.rd1 = '0;
            bus.rd2 = '0;
        end
    end

    load_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (bus.ld_issue),
        .set_idx (bus.ld_dst),
        .clr_en  (bus.we && bus.ld_done),
        .clr_idx (bus.wa),
        .la1     (bus.ra1),
        .la2     (bus.ra2),
        .pend1   (pend1),
        .pend2   (pend2)
    );

    // A register whose load is retiring right now already has its data on the bypass.
    assign bus.stall = !rst &&
                       ((pend1 && !(retire && bus.wa == bus.ra1)) ||
                        (pend2 && !(retire && bus.wa == bus.ra2)));
endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: array/scoreboard model checked every cycle plus literal spot checks.
module tb_regfile_wb;
    import regfile_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mreg  [DEPTH];
    bit          mpend [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: plain array and pending flags, updated from the architectural rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mreg[i]  = '0;
                mpend[i] = 1'b0;
            end
        end else begin
            if (bus.we && bus.wa != 0) mreg[bus.wa] = bus.wd;
            if (bus.we && bus.ld_done) mpend[bus.wa] = 1'b0;
            if (bus.ld_issue && bus.ld_dst != 0) mpend[bus.ld_dst] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (rst || a == 0) return '0;
        if (bus.we && bus.wa == a) return bus.wd;
        return mreg[a];
    endfunction

    function automatic logic port_stall(input logic [4:0] a);
        if (rst) return 1'b0;
        return mpend[a] && !(bus.we && bus.ld_done && bus.wa == a);
    endfunction

    always @(negedge clk) begin
        check("cyc_rd1", bus.rd1, exp_read(bus.ra1));
        check("cyc_rd2", bus.rd2, exp_read(bus.ra2));
        check("cyc_stall", {31'd0, bus.stall},
              {31'd0, port_stall(bus.ra1) | port_stall(bus.ra2)});
    end

    task automatic idle();
        bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.ld_issue = 1'b0; bus.ld_dst = '0; bus.ld_done = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mreg[i]  = '0;
            mpend[i] = 1'b0;
        end
        idle();
        bus.ra1 = '0; bus.ra2 = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_rd1", bus.rd1, 32'h0);
        check("rst_stall", {31'd0, bus.stall}, 32'h0);
        // Writes and load issues while reset is held must be ignored.
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'hCAFE0007; bus.ra1 = 5'd7;
        bus.ld_issue = 1'b1; bus.ld_dst = 5'd7;
        #1;
        check("rst_bypass_rd1", bus.rd1, 32'h0);
        check("rst_stall_issue", {31'd0, bus.stall}, 32'h0);
        @(posedge clk); #1;
        idle();
        #1 rst = 1'b0;
        step();

        for (int i = 0; i < 32; i++) begin
            bus.ra1 = 5'(i); bus.ra2 = 5'(31 - i);
            #1;
            check("sweep_rd1", bus.rd1, 32'h0);
            check("sweep_rd2", bus.rd2, 32'h0);
            check("sweep_stall", {31'd0, bus.stall}, 32'h0);
            step();
        end

        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEADBEEF; bus.ra1 = 5'd5; bus.ra2 = 5'd0;
        #1 check("bypass_rd1", bus.rd1, 32'hDEADBEEF);
        step(); idle();
        #1 check("array_rd1", bus.rd1, 32'hDEADBEEF);

        bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF; bus.ra1 = 5'd0;
        #1 check("r0_bypass", bus.rd1, 32'h0);
        step(); idle();
        #1 check("r0_read", bus.rd1, 32'h0);

        bus.ld_issue = 1'b1; bus.ld_dst = 5'd8; bus.ra2 = 5'd8;
        #1 check("ld8_not_yet", {31'd0, bus.stall}, 32'h0);
        step(); idle();
        #1 check("ld8_stall", {31'd0, bus.stall}, 32'h1);
        bus.we = 1'b1; bus.ld_done = 1'b1; bus.wa = 5'd8; bus.wd = 32'h1234;
        #1 check("ld8_retire_stall", {31'd0, bus.stall}, 32'h0);
        check("ld8_retire_rd2", bus.rd2, 32'h1234);
        step(); idle();
        #1 check("ld8_after_stall", {31'd0, bus.stall}, 32'h0);
        check("ld8_after_rd2", bus.rd2, 32'h1234);

        bus.ld_issue = 1'b1; bus.ld_dst = 5'd9;
        bus.we = 1'b1; bus.ld_done = 1'b1; bus.wa = 5'd9; bus.wd = 32'h99; bus.ra1 = 5'd9; bus.ra2 = 5'd0;
        step(); idle();
        #1 check("ld9_newwins_stall", {31'd0, bus.stall}, 32'h1);
        check("ld9_rd1", bus.rd1, 32'h99);
        bus.we = 1'b1; bus.ld_done = 1'b1; bus.wa = 5'd9; bus.wd = 32'hA9;
        step(); idle();
        #1 check("ld9_cleared", {31'd0, bus.stall}, 32'h0);

        bus.ld_issue = 1'b1; bus.ld_dst = 5'd10;
        step(); idle();
        bus.ld_done = 1'b1; bus.wa = 5'd10; bus.ra1 = 5'd0; bus.ra2 = 5'd10;
        #1 check("done_no_we_stall", {31'd0, bus.stall}, 32'h1);
        step(); idle();
        #1 check("done_no_we_kept", {31'd0, bus.stall}, 32'h1);
        bus.we = 1'b1; bus.ld_done = 1'b1; bus.wa = 5'd10; bus.wd = 32'h10;
        step(); idle();

        bus.we = 1'b1; bus.ld_done = 1'b1; bus.wa = 5'd11; bus.wd = 32'hB0B0; bus.ra1 = 5'd11; bus.ra2 = 5'd0;
        step(); idle();
        #1 check("done_notpend_rd1", bus.rd1, 32'hB0B0);
        check("done_notpend_stall", {31'd0, bus.stall}, 32'h0);

        bus.ld_issue = 1'b1; bus.ld_dst = 5'd0;
        step(); idle();
        bus.ra1 = 5'd0; bus.ra2 = 5'd0;
        #1 check("ld_r0_ignored", {31'd0, bus.stall}, 32'h0);

        bus.ld_issue = 1'b1; bus.ld_dst = 5'd12;
        step();
        bus.ld_dst = 5'd13;
        step(); idle();
        bus.we = 1'b1; bus.ld_done = 1'b1; bus.wa = 5'd12; bus.wd = 32'hC12; bus.ra1 = 5'd12; bus.ra2 = 5'd13;
        #1 check("port2_still_stalls", {31'd0, bus.stall}, 32'h1);
        step(); idle();
        bus.ra2 = 5'd0;
        #1 check("port1_clear_stall", {31'd0, bus.stall}, 32'h0);
        check("port1_rd1", bus.rd1, 32'hC12);

        // Asynchronous reset pulse landing between clock edges.
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h55;
        step(); idle();
        bus.ld_issue = 1'b1; bus.ld_dst = 5'd3;
        step(); idle();
        bus.ra1 = 5'd3; bus.ra2 = 5'd13;
        #1 check("pre_rst_rd1", bus.rd1, 32'h55);
        check("pre_rst_stall", {31'd0, bus.stall}, 32'h1);
        #1 rst = 1'b1;
        #1 check("async_rst_rd1", bus.rd1, 32'h0);
        check("async_rst_stall", {31'd0, bus.stall}, 32'h0);
        #3 rst = 1'b0;
        step();
        check("post_rst_rd1", bus.rd1, 32'h0);
        check("post_rst_stall", {31'd0, bus.stall}, 32'h0);
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h77;
        step(); idle();
        #1 check("resume_rd1", bus.rd1, 32'h77);

        for (int i = 1; i < 32; i++) begin
            bus.we = 1'b1; bus.wa = 5'(i); bus.wd = (32'h01010101 * i) ^ 32'hA5A5_0000;
            bus.ra1 = 5'(i); bus.ra2 = 5'(i - 1);
            bus.ld_issue = (i % 3 == 0); bus.ld_dst = 5'(i + 1);
            bus.ld_done = (i % 4 == 0);
            step();
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            bus.ra1 = 5'(i); bus.ra2 = 5'(31 - i);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
